// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
// Provides widths, FSM state encodings, owner encodings, default limits
// and the packed request payload latched at grant time.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'b01;
    localparam logic [STATE_W-1:0] ST_BUSY  = 2'b10;
    localparam logic [STATE_W-1:0] ST_RESP  = 2'b11;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [CNT_W-1:0] STARVE_LIMIT_DEF = 6'd3;
    localparam logic [CNT_W-1:0] TIMEOUT_DEF      = 6'd63;

    // Payload captured from the winning requester at grant time
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating up-counter with clear/enable; expire_c flags count == limit.
// Used as the BUSY watchdog and as the fetch-starvation age counter.
// Ports: clk, rst (async active-low), clr (priority over en), en,
//        limit (saturation/expire value), expire_c (combinational).
module mem_arb_timer
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire_c
);

    logic [CNT_W-1:0] count;

    assign expire_c = (count == limit);

    // Count up to limit and hold there until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mem_system port between instruction fetch and data memory.
// Data has priority; an age counter forces fetch after STARVE_LIMIT data
// grants; a watchdog aborts a transaction with no m_done and sets err.
// Ports: clk, rst (async active-low); fetch i_rd/i_addr -> i_done/i_rdata/
//        i_stall; data d_rd/d_wr/d_addr/d_wdata -> d_done/d_rdata/d_stall;
//        mem_system m_rd/m_wr/m_addr/m_wdata <- m_done/m_rdata/m_hit;
//        hit (last completed), err (sticky).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [CNT_W-1:0] STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT      = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_hit,
    output logic              m_rd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              hit,
    output logic              err
);

    logic [STATE_W-1:0] state, state_nxt;
    logic               owner, owner_nxt;
    logic               op_wr, op_wr_nxt;
    logic               m_rd_nxt, m_wr_nxt;
    logic [ADDR_W-1:0]  m_addr_nxt;
    logic [DATA_W-1:0]  m_wdata_nxt;
    logic               i_done_nxt, d_done_nxt;
    logic [DATA_W-1:0]  i_rdata_nxt, d_rdata_nxt;
    logic               hit_nxt, err_nxt;

    logic     d_req;
    logic     grant_i, grant_d;
    logic     age_exp, wd_exp;
    mem_req_t req_sel;

    // Arbitration: data first unless fetch has waited STARVE_LIMIT grants
    assign d_req   = d_rd | d_wr;
    assign grant_i = (state == ST_IDLE) & i_rd & (~d_req | age_exp);
    assign grant_d = (state == ST_IDLE) & d_req & ~grant_i;

    mem_arb_timer u_age (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_i),
        .en       (grant_d & i_rd),
        .limit    (STARVE_LIMIT),
        .expire_c (age_exp)
    );

    // Expires on the TIMEOUT-th BUSY cycle (count starts at 0 on entry)
    mem_arb_timer u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != ST_BUSY),
        .en       (state == ST_BUSY),
        .limit    (TIMEOUT - CNT_W'(1)),
        .expire_c (wd_exp)
    );

    // Payload of the winner; simultaneous d_rd&d_wr is treated as a write
    always_comb begin
        if (grant_i) begin
            req_sel = '{wr: 1'b0, addr: i_addr, wdata: DATA_W'(0)};
        end else begin
            req_sel = '{wr: d_wr, addr: d_addr, wdata: d_wdata};
        end
    end

    // Stall is combinational; forced low while reset is asserted
    assign i_stall = rst & i_rd  & ~((state == ST_RESP) & (owner == OWNER_I));
    assign d_stall = rst & d_req & ~((state == ST_RESP) & (owner == OWNER_D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        op_wr_nxt   = op_wr;
        m_rd_nxt    = 1'b0;
        m_wr_nxt    = 1'b0;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        i_done_nxt  = 1'b0;
        d_done_nxt  = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        hit_nxt     = hit;
        err_nxt     = err;

        case (state)
            ST_IDLE: begin
                if (d_rd && d_wr) begin
                    err_nxt = 1'b1;
                end
                if (grant_i || grant_d) begin
                    owner_nxt   = grant_i ? OWNER_I : OWNER_D;
                    op_wr_nxt   = req_sel.wr;
                    m_rd_nxt    = ~req_sel.wr;
                    m_wr_nxt    = req_sel.wr;
                    m_addr_nxt  = req_sel.addr;
                    m_wdata_nxt = req_sel.wdata;
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (m_done) begin
                    hit_nxt = m_hit;
                    if (owner == OWNER_I) begin
                        i_done_nxt  = 1'b1;
                        i_rdata_nxt = m_rdata;
                    end else begin
                        d_done_nxt = 1'b1;
                        if (!op_wr) begin
                            d_rdata_nxt = m_rdata;
                        end
                    end
                    state_nxt = ST_RESP;
                end else if (wd_exp) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= OWNER_I;
            op_wr   <= 1'b0;
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            hit     <= 1'b0;
            err     <= 1'b0;
        end else begin
            owner   <= owner_nxt;
            op_wr   <= op_wr_nxt;
            m_rd    <= m_rd_nxt;
            m_wr    <= m_wr_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            i_done  <= i_done_nxt;
            d_done  <= d_done_nxt;
            i_rdata <= i_rdata_nxt;
            d_rdata <= d_rdata_nxt;
            hit     <= hit_nxt;
            err     <= err_nxt;
        end
    end

endmodule
